// File: rtl/digit_tube_mmio_pkg.sv
// Register map, CTRL field layout and reset values shared by the digit tube scanner.
package digit_tube_mmio_pkg;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_CTRL  = 2'd1,
        REG_INDEX = 2'd2,
        REG_RSVD  = 2'd3
    } reg_off_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 1;
    localparam int CTRL_BRIGHT_W   = 3;
    localparam int CTRL_DP_LSB     = 4;
    localparam int CTRL_BLANK_LSB  = 12;

    localparam logic [31:0] CTRL_RST = 32'h0000_000F;
    localparam logic [7:0]  SEG_OFF  = 8'hFF;

    // One nibble per implemented digit; the rest of DATA is not storage.
    function automatic logic [31:0] data_mask(input int digits);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) m[4*i +: 4] = 4'hF;
        end
        return m;
    endfunction

    function automatic logic [31:0] ctrl_mask(input int digits);
        logic [31:0] m;
        m = 32'h0000_000F;
        for (int i = 0; i < 8; i++) begin
            if (i < digits) begin
                m[CTRL_DP_LSB + i]    = 1'b1;
                m[CTRL_BLANK_LSB + i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/digit_tube_mmio_hex_seg_decode.sv
// Hex nibble to active-low g..a segment pattern; purely combinational, no flow control.
module hex_seg_decode (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/digit_tube_mmio.sv
// Memory-mapped multiplexed 7-segment scanner with PWM brightness; read data one cycle after strobe,
// sel/driver one cycle behind scan state; bus never stalls (no backpressure).
module digit_tube_mmio
    import digit_tube_mmio_pkg::*;
#(
    parameter int          DIGITS    = 4,
    parameter int          SCAN_DIV  = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_w_enable_i,
    input  logic [31:0]       mem_w_addr_i,
    input  logic [31:0]       mem_w_data_i,
    input  logic              mem_r_enable_i,
    input  logic [31:0]       mem_r_addr_i,
    output logic [31:0]       mem_r_data_o,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        driver
);

    localparam int STEP  = SCAN_DIV / 8;
    localparam int SUB_W = (STEP > 1) ? $clog2(STEP) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] DATA_MASK = data_mask(DIGITS);
    localparam logic [31:0] CTRL_MASK = ctrl_mask(DIGITS);

    logic [31:0]       data_q, data_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              run_q, run_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [2:0]        phase_q, phase_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [7:0]        drv_q, drv_d;

    logic              ctrl_en;
    logic [2:0]        bright;
    logic [DIGITS-1:0] dp_mask;
    logic [DIGITS-1:0] blank_mask;
    logic              w_hit, r_hit;
    reg_off_e          w_off, r_off;
    logic [31:0]       rd_val;
    logic [3:0]        nib;
    logic [6:0]        seg;
    logic              scan_on, lit;
    logic              unused_bits;

    assign ctrl_en    = ctrl_q[CTRL_EN_BIT];
    assign bright     = ctrl_q[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
    assign dp_mask    = ctrl_q[CTRL_DP_LSB +: DIGITS];
    assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: DIGITS];

    assign w_hit = mem_w_enable_i && (mem_w_addr_i[31:4] == BASE_ADDR[31:4]);
    assign r_hit = mem_r_enable_i && (mem_r_addr_i[31:4] == BASE_ADDR[31:4]);
    assign w_off = reg_off_e'(mem_w_addr_i[3:2]);
    assign r_off = reg_off_e'(mem_r_addr_i[3:2]);

    assign unused_bits = ^{mem_w_addr_i[1:0], mem_r_addr_i[1:0], ctrl_q, data_q};

    assign nib = data_q[{idx_q, 2'b00} +: 4];

    hex_seg_decode u_dec (
        .hex_i (nib),
        .seg_o (seg)
    );

    always_comb begin
        rd_val = '0;
        case (r_off)
            REG_DATA:  rd_val = data_q;
            REG_CTRL:  rd_val = ctrl_q;
            REG_INDEX: rd_val = 32'(idx_q);
            default:   rd_val = '0;
        endcase
    end

    // Register writes land at the edge; reads sample the pre-write value in the same cycle.
    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (w_hit) begin
            case (w_off)
                REG_DATA: data_d = mem_w_data_i & DATA_MASK;
                REG_CTRL: ctrl_d = mem_w_data_i & CTRL_MASK;
                default:  ;
            endcase
        end
        rdata_d = mem_r_enable_i ? (r_hit ? rd_val : '0) : rdata_q;
    end

    // run_q delays scanning by one edge after enable, so the first slot starts cleanly at index 0.
    always_comb begin
        run_d   = ctrl_en;
        sub_d   = sub_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        if (!ctrl_en) begin
            sub_d   = '0;
            phase_d = '0;
            idx_d   = '0;
        end else if (run_q) begin
            if (sub_q == SUB_W'(STEP - 1)) begin
                sub_d   = '0;
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd7) begin
                    idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    always_comb begin
        scan_on = run_q && ctrl_en;
        lit     = scan_on && !blank_mask[idx_q] && (phase_q <= bright);
        sel_d   = scan_on ? (DIGITS'(1) << idx_q) : '0;
        drv_d   = lit ? {~dp_mask[idx_q], seg} : SEG_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            ctrl_q  <= CTRL_RST & CTRL_MASK;
            rdata_q <= '0;
            run_q   <= 1'b0;
            sub_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            drv_q   <= SEG_OFF;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            run_q   <= run_d;
            sub_q   <= sub_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            drv_q   <= drv_d;
        end
    end

    assign mem_r_data_o = rdata_q;
    assign sel          = sel_q;
    assign driver       = drv_q;

endmodule

// File: tb/tb_digit_tube_mmio.sv
// Scoreboard bench for digit_tube_mmio with DIGITS=4, SCAN_DIV=16 (16-cycle slots, 2 cycles per phase).
module tb_digit_tube_mmio;

    localparam logic [31:0] BASE = 32'h0000_0F00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_w_enable_i;
    logic [31:0] mem_w_addr_i;
    logic [31:0] mem_w_data_i;
    logic        mem_r_enable_i;
    logic [31:0] mem_r_addr_i;
    logic [31:0] mem_r_data_o;
    logic [3:0]  sel;
    logic [7:0]  driver;

    digit_tube_mmio #(
        .DIGITS    (4),
        .SCAN_DIV  (16),
        .BASE_ADDR (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_w_enable_i (mem_w_enable_i),
        .mem_w_addr_i   (mem_w_addr_i),
        .mem_w_data_i   (mem_w_data_i),
        .mem_r_enable_i (mem_r_enable_i),
        .mem_r_addr_i   (mem_r_addr_i),
        .mem_r_data_o   (mem_r_data_o),
        .sel            (sel),
        .driver         (driver)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          is_rd;
        logic [3:0]  sel;
        logic [7:0]  drv;
        logic [31:0] rd;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_it;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    // Cycle at which the display shows scan count 0 (index 0, phase 0).
    int   anchor = 2;

    // Segment bytes for DATA = 0x0000_F810 with dp off.
    logic [7:0] dig [4] = '{8'hC0, 8'hF9, 8'h80, 8'h8E};

    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    function automatic int idx_of(input int c);
        return ((c - anchor) / 16) % 4;
    endfunction

    function automatic int next_slot(input int c);
        return c + ((16 - ((c - anchor) % 16)) % 16);
    endfunction

    function automatic void push_disp(input int c, input logic [3:0] s, input logic [7:0] d, input string n);
        exp_t e;
        e.cyc = c; e.is_rd = 1'b0; e.sel = s; e.drv = d; e.rd = '0; e.name = n;
        sb.push_back(e);
    endfunction

    function automatic void push_rd(input int c, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc = c; e.is_rd = 1'b1; e.sel = '0; e.drv = '0; e.rd = v; e.name = n;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_it = sb.pop_front();
            checks++;
            if (mon_it.cyc != cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d not reached (now %0d)", mon_it.name, mon_it.cyc, cyc);
            end else if (mon_it.is_rd) begin
                if (mem_r_data_o !== mon_it.rd) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: rdata=%h want %h", mon_it.name, cyc, mem_r_data_o, mon_it.rd);
                end
            end else if (sel !== mon_it.sel || driver !== mon_it.drv) begin
                errors++;
                $display("FAIL %s cyc=%0d: sel=%b driver=%h want sel=%b driver=%h",
                         mon_it.name, cyc, sel, driver, mon_it.sel, mon_it.drv);
            end
        end
    end

    task automatic drain(input int budget, input string n);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: %0d checks pending after %0d cycles, want 0", n, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_w_enable_i = 1'b1;
        mem_w_addr_i   = a;
        mem_w_data_i   = d;
        @(posedge clk);
        #1;
        mem_w_enable_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] ev, input bit want_idx, input string n);
        @(negedge clk);
        mem_r_enable_i = 1'b1;
        mem_r_addr_i   = a;
        push_rd(cyc + 1, want_idx ? 32'(idx_of(cyc + 1)) : ev, n);
        @(posedge clk);
        #1;
        mem_r_enable_i = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d, input logic [31:0] ev, input string n);
        @(negedge clk);
        mem_r_enable_i = 1'b1;
        mem_r_addr_i   = a;
        mem_w_enable_i = 1'b1;
        mem_w_addr_i   = a;
        mem_w_data_i   = d;
        push_rd(cyc + 1, ev, n);
        @(posedge clk);
        #1;
        mem_r_enable_i = 1'b0;
        mem_w_enable_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int k;
        logic [7:0] e;

        rst_n          = 1'b0;
        mem_w_enable_i = 1'b0;
        mem_w_addr_i   = '0;
        mem_w_data_i   = '0;
        mem_r_enable_i = 1'b0;
        mem_r_addr_i   = '0;

        // Reset state, first sel on the second edge after release, then the default scan.
        push_disp(0, 4'b0000, 8'hFF, "reset_out");
        push_rd(0, 32'h0, "reset_rdata");
        push_disp(1, 4'b0000, 8'hFF, "first_edge");
        foreach (dig[i]) begin end
        for (int i = 0; i < 9; i++) begin
            int pts [9] = '{2, 17, 18, 33, 34, 49, 50, 65, 66};
            push_disp(pts[i], 4'b0001 << idx_of(pts[i]), 8'hC0, "scan_default");
        end
        #22 rst_n = 1'b1;
        drain(120, "default");

        // Per-digit hex decode.
        wr(BASE, 32'h0000_F810);
        s = next_slot(cyc + 1);
        for (int j = 0; j < 4; j++) begin
            c = s + 16 * j + 5;
            k = idx_of(c);
            push_disp(c, 4'b0001 << k, dig[k], "hex_digit");
        end
        drain(120, "hex");

        // Brightness 2: six lit cycles then ten dark cycles per slot.
        wr(BASE + 32'h4, 32'h0000_0005);
        s = next_slot(cyc + 1);
        for (int off = 0; off < 16; off++) begin
            k = idx_of(s + off);
            push_disp(s + off, 4'b0001 << k, (off < 6) ? dig[k] : 8'hFF, "bright2");
        end
        drain(60, "bright");

        // dp on digit 1, digit 0 blanked, brightness 0 (phase 0 only).
        wr(BASE + 32'h4, 32'h0000_1021);
        s = next_slot(cyc + 1);
        for (int j = 0; j < 4; j++) begin
            c = s + 16 * j;
            k = idx_of(c);
            e = (k == 0) ? 8'hFF : (k == 1) ? 8'h79 : dig[k];
            push_disp(c,     4'b0001 << k, e,     "dp_blank_p0a");
            push_disp(c + 1, 4'b0001 << k, e,     "dp_blank_p0b");
            push_disp(c + 2, 4'b0001 << k, 8'hFF, "dp_blank_p1");
        end
        drain(120, "dpblank");

        // Disable mid-slot, then re-enable and restart at digit 0.
        repeat (7) @(negedge clk);
        wr(BASE + 32'h4, 32'h0000_0000);
        push_disp(cyc + 1, 4'b0000, 8'hFF, "disable_next");
        push_disp(cyc + 8, 4'b0000, 8'hFF, "disable_hold");
        drain(20, "disable");
        wr(BASE + 32'h4, 32'h0000_000F);
        anchor = cyc + 2;
        push_disp(cyc + 1,  4'b0000, 8'hFF, "reenable_gap");
        push_disp(cyc + 2,  4'b0001, 8'hC0, "reenable_d0");
        push_disp(cyc + 17, 4'b0001, 8'hC0, "reenable_d0_end");
        push_disp(cyc + 18, 4'b0010, 8'hF9, "reenable_d1");
        drain(40, "reenable");

        // Register reads.
        rw(BASE, 32'h0000_1234, 32'h0000_F810, "rw_prewrite");
        rd(BASE, 32'h0000_1234, 1'b0, "rd_data");
        push_rd(cyc + 1, 32'h0000_1234, "rd_hold");
        drain(10, "hold");
        rd(BASE + 32'h10, 32'h0, 1'b0, "rd_nohit");
        rd(BASE + 32'h7, 32'h0000_000F, 1'b0, "rd_ctrl_lowbits");
        rd(BASE + 32'h8, 32'h0, 1'b1, "rd_index");
        rd(BASE + 32'hC, 32'h0, 1'b0, "rd_rsvd");
        wr(BASE + 32'h10, 32'hDEAD_BEEF);
        rd(BASE, 32'h0000_1234, 1'b0, "nohit_write");
        wr(BASE, 32'hABCD_5678);
        rd(BASE, 32'h0000_5678, 1'b0, "data_mask");
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        rd(BASE + 32'h4, 32'h0000_F0FF, 1'b0, "ctrl_mask");
        push_disp(cyc + 1, 4'b0001 << idx_of(cyc + 1), 8'hFF, "all_blank");
        drain(20, "reads");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
